// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pkg
// Description : Shared defaults for the arbitrated fixed-point multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_mul_pkg;

    localparam int C_N_REQ_DEF = 4;
    localparam int C_I_DEF     = 2;
    localparam int C_F_DEF     = 14;
    localparam int C_W_DEF     = C_I_DEF + C_F_DEF;
    localparam int C_ID_W_DEF  = $clog2(C_N_REQ_DEF);

    // Saturation pattern; users slice the low W bits.
    localparam logic [63:0] C_SAT_ALL = '1;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_sm_mul.sv
`default_nettype none
// ============================================================================
// Module      : fxp_sm_mul
// Description : Combinational sign-magnitude I.F multiply with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_sm_mul
    import fp_mul_pkg::*;
#(
    parameter int I = C_I_DEF,
    parameter int F = C_F_DEF,
    parameter int W = I + F
) (
    input  logic [W-1:0] i_a,
    input  logic         i_sa,
    input  logic [W-1:0] i_b,
    input  logic         i_sb,
    output logic [W-1:0] o_c,
    output logic         o_sign,
    output logic         o_ovf
);

    localparam logic [W-1:0] C_SAT = C_SAT_ALL[W-1:0];

    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_shift;

    assign w_prod  = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
    // Dropping the low F bits truncates toward zero; anything left above W overflows.
    assign w_shift = w_prod >> F;
    assign o_ovf   = |w_shift[2*W-1:W];
    assign o_c     = o_ovf ? C_SAT : w_shift[W-1:0];
    assign o_sign  = (i_sa ^ i_sb) & (|o_c);

endmodule
`default_nettype wire

// File: rtl/fp_mul_arb.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_arb
// Description : Round-robin arbiter sharing one two-stage fixed-point multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_arb
    import fp_mul_pkg::*;
#(
    parameter int  N_REQ = C_N_REQ_DEF,
    parameter int  I     = C_I_DEF,
    parameter int  F     = C_F_DEF,
    localparam int W     = I + F,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ-1:0]   req_sa,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_sb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_c,
    output logic               rsp_sign,
    output logic               rsp_ovf,
    output logic [N_REQ-1:0]   ovf_sticky,
    input  logic               ovf_clr
);

    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_s1_valid;
    logic [W-1:0]     r_s1_a;
    logic [W-1:0]     r_s1_b;
    logic             r_s1_sa;
    logic             r_s1_sb;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_s2_valid;
    logic [W-1:0]     r_s2_c;
    logic             r_s2_sign;
    logic             r_s2_ovf;
    logic [ID_W-1:0]  r_s2_id;
    logic [N_REQ-1:0] r_sticky;

    logic             w_gnt_any;
    logic [ID_W-1:0]  w_gnt_id;
    logic [ID_W-1:0]  w_probe;
    int               w_idx;
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic [ID_W-1:0]  w_next_ptr;
    logic [W-1:0]     w_mul_c;
    logic             w_mul_sign;
    logic             w_mul_ovf;
    logic [N_REQ-1:0] w_set_mask;

    // Scan downward so the last hit is the closest requester at or after r_rr_ptr.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_idx     = 0;
        w_probe   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            w_probe = ID_W'(w_idx);
            if (req_valid[w_probe]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_probe;
            end
        end
    end

    assign w_s2_adv   = ~r_s2_valid | rsp_ready;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign w_accept   = w_gnt_any & w_s1_adv & ~rst;
    assign w_next_ptr = (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_sa    <= 1'b0;
            r_s1_sb    <= 1'b0;
            r_s1_id    <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_next_ptr;
                r_s1_a   <= req_a[w_gnt_id*W +: W];
                r_s1_b   <= req_b[w_gnt_id*W +: W];
                r_s1_sa  <= req_sa[w_gnt_id];
                r_s1_sb  <= req_sb[w_gnt_id];
                r_s1_id  <= w_gnt_id;
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
            end
        end
    end

    fxp_sm_mul #(
        .I (I),
        .F (F),
        .W (W)
    ) u_mul (
        .i_a    (r_s1_a),
        .i_sa   (r_s1_sa),
        .i_b    (r_s1_b),
        .i_sb   (r_s1_sb),
        .o_c    (w_mul_c),
        .o_sign (w_mul_sign),
        .o_ovf  (w_mul_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_c     <= '0;
            r_s2_sign  <= 1'b0;
            r_s2_ovf   <= 1'b0;
            r_s2_id    <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_c    <= w_mul_c;
                r_s2_sign <= w_mul_sign;
                r_s2_ovf  <= w_mul_ovf;
                r_s2_id   <= r_s1_id;
            end
        end
    end

    always_comb begin
        w_set_mask = '0;
        if (r_s2_valid && rsp_ready && r_s2_ovf) begin
            w_set_mask[r_s2_id] = 1'b1;
        end
    end

    // A set landing with ovf_clr in the same cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (ovf_clr ? '0 : r_sticky) | w_set_mask;
        end
    end

    assign rsp_valid  = r_s2_valid;
    assign rsp_c      = r_s2_c;
    assign rsp_sign   = r_s2_sign;
    assign rsp_ovf    = r_s2_ovf;
    assign rsp_id     = r_s2_id;
    assign ovf_sticky = r_sticky;

endmodule
`default_nettype wire
